// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions: memory-stage state encoding, the decoded control
// bundle layout and small helpers for classifying an accepted instruction.
package mem_access_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned TO_BITS = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } ma_state_e;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
    } ctl_t;

    // A branch is never a memory access, whatever its memory bits say.
    function automatic logic is_mem_op(input ctl_t c);
        return (c.mem_read || c.mem_write) && !c.branch;
    endfunction

    function automatic logic is_illegal(input ctl_t c, input logic [1:0] addr_lo);
        return (addr_lo != 2'b00) || (c.mem_read && c.mem_write);
    endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage: accepts one instruction from execute, performs
// an optional word load/store on the data bus, and emits a registered writeback.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   pc_n,
    input  logic              zero,
    input  logic [XLEN-1:0]   ALUout,
    input  logic [XLEN-1:0]   regData2,
    input  logic [REG_AW-1:0] r_d,
    input  logic              ctl_mem_read,
    input  logic              ctl_mem_write,
    input  logic              ctl_branch,
    input  logic              ctl_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              pc_src,
    output logic [XLEN-1:0]   branch_target,
    output logic              err_align,
    output logic              err_timeout
);

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    ma_state_e           state_q, state_d;
    logic [TO_BITS-1:0]  cnt_q, cnt_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]     dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic                pc_src_q, pc_src_d;
    logic [XLEN-1:0]     branch_target_q, branch_target_d;
    logic                err_align_q, err_align_d;
    logic                err_timeout_q, err_timeout_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                pend_reg_write_q, pend_reg_write_d;

    ctl_t ctl;
    logic accept;

    assign ex_ready = (state_q == ST_IDLE);
    assign accept   = ex_valid && ex_ready;
    assign ctl      = '{mem_read:  ctl_mem_read,  mem_write: ctl_mem_write,
                        branch:    ctl_branch,    reg_write: ctl_reg_write};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        dmem_req_d       = dmem_req_q;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        wb_valid_d       = 1'b0;
        wb_data_d        = wb_data_q;
        wb_rd_d          = wb_rd_q;
        wb_reg_write_d   = wb_reg_write_q;
        pc_src_d         = 1'b0;
        branch_target_d  = branch_target_q;
        err_align_d      = 1'b0;
        err_timeout_d    = err_timeout_q;
        pend_rd_d        = pend_rd_q;
        pend_reg_write_d = pend_reg_write_q;

        unique case (state_q)
            ST_IDLE: begin
                // Inputs are only looked at on the accept edge; dmem_ack here is ignored.
                if (accept) begin
                    branch_target_d = pc_n;
                    pc_src_d        = ctl_branch && zero;
                    if (!is_mem_op(ctl)) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ALUout;
                        wb_rd_d        = r_d;
                        wb_reg_write_d = ctl_reg_write;
                    end else if (is_illegal(ctl, ALUout[1:0])) begin
                        err_align_d    = 1'b1;
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ALUout;
                        wb_rd_d        = r_d;
                        wb_reg_write_d = 1'b0;
                    end else begin
                        state_d          = ST_ACCESS;
                        cnt_d            = '0;
                        dmem_req_d       = 1'b1;
                        dmem_we_d        = ctl_mem_write;
                        dmem_addr_d      = ALUout;
                        dmem_wdata_d     = regData2;
                        pend_rd_d        = r_d;
                        pend_reg_write_d = ctl_reg_write;
                    end
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    // A store writes back its address and never a register.
                    state_d        = ST_IDLE;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = pend_rd_q;
                    wb_data_d      = dmem_we_q ? dmem_addr_q : dmem_rdata;
                    wb_reg_write_d = dmem_we_q ? 1'b0 : pend_reg_write_q;
                end else if (cnt_q == TO_LAST) begin
                    state_d        = ST_IDLE;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    err_timeout_d  = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = pend_rd_q;
                    wb_data_d      = dmem_addr_q;
                    wb_reg_write_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            wb_valid_q       <= 1'b0;
            wb_data_q        <= '0;
            wb_rd_q          <= '0;
            wb_reg_write_q   <= 1'b0;
            pc_src_q         <= 1'b0;
            branch_target_q  <= '0;
            err_align_q      <= 1'b0;
            err_timeout_q    <= 1'b0;
            pend_rd_q        <= '0;
            pend_reg_write_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dmem_req_q       <= dmem_req_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            wb_valid_q       <= wb_valid_d;
            wb_data_q        <= wb_data_d;
            wb_rd_q          <= wb_rd_d;
            wb_reg_write_q   <= wb_reg_write_d;
            pc_src_q         <= pc_src_d;
            branch_target_q  <= branch_target_d;
            err_align_q      <= err_align_d;
            err_timeout_q    <= err_timeout_d;
            pend_rd_q        <= pend_rd_d;
            pend_reg_write_q <= pend_reg_write_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign pc_src        = pc_src_q;
    assign branch_target = branch_target_q;
    assign err_align     = err_align_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, 16, number of ACCESS cycles without dmem_ack before the access is aborted (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ex_valid  in  1  execute stage presents a valid instruction.
REQ-005 ex_ready  out  1  mem_access accepts; transfer occurs on an edge where ex_valid & ex_ready.
REQ-006 pc_n  in  32  PC from execute; the branch target.
REQ-007 zero  in  1  execute compare result.
REQ-008 ALUout  in  32  ALU result, or effective address for load/store.
REQ-009 regData2  in  32  store data.
REQ-010 r_d  in  5  destination register.
REQ-011 ctl_mem_read, ctl_mem_write, ctl_branch, ctl_reg_write  in  1 each  decoded control.
REQ-012 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32  data-memory request.
REQ-013 dmem_ack  in  1; dmem_rdata  in  32  memory completion and load data.
REQ-014 wb_valid  out  1; wb_data  out  32; wb_rd  out  5; wb_reg_write  out  1  writeback result.
REQ-015 pc_src  out  1; branch_target  out  32  branch redirect.
REQ-016 err_align  out  1  one-cycle misaligned/illegal-access pulse; err_timeout  out  1  sticky bus-timeout flag.

Function
REQ-017 States IDLE and ACCESS; ex_ready = (state == IDLE), combinational from state only.
REQ-018 On accept, all inputs are captured; no input is used after the accept edge.
REQ-019 Non-memory op (neither ctl_mem_read nor ctl_mem_write): state stays IDLE; in the next cycle wb_valid=1, wb_data=ALUout, wb_rd=r_d, wb_reg_write=ctl_reg_write.
REQ-020 Memory op with ALUout[1:0]==0 and not both read and write: enter ACCESS; from the next cycle, dmem_req=1, dmem_addr=ALUout, dmem_we=ctl_mem_write, dmem_wdata=regData2, all held stable until the ack edge.
REQ-021 In ACCESS, an edge with dmem_ack=1 returns to IDLE, drops dmem_req in the following cycle, and produces wb_valid=1 for that cycle; load: wb_data=dmem_rdata sampled at the ack edge, wb_reg_write=ctl_reg_write; store: wb_data=ALUout, wb_reg_write=0.
REQ-022 dmem_ack while in IDLE is ignored.
REQ-023 Misaligned address, or read and write both set: no dmem_req; next cycle err_align=1 and wb_valid=1 with wb_reg_write=0; state stays IDLE.
REQ-024 Timeout: 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without ack; when it reaches TIMEOUT, return to IDLE, deassert dmem_req, set err_timeout (cleared only by reset), emit wb_valid with wb_reg_write=0; an ack on that same edge takes precedence as a normal completion.
REQ-025 wb_valid, err_align and pc_src are single-cycle pulses; wb_data and wb_rd hold their last values when wb_valid=0.
REQ-026 pc_src=1 for exactly the cycle after accept when ctl_branch & zero; branch_target=pc_n captured at accept; a branch never enters ACCESS.
REQ-027 Best-case throughput is one non-memory op per cycle; a memory op blocks acceptance until its completion or timeout edge, and acceptance resumes in the cycle after.

Reset
REQ-028 rst asynchronously forces state=IDLE, counter=0, and dmem_req, dmem_we, wb_valid, wb_reg_write, pc_src, err_align, err_timeout=0, plus dmem_addr, dmem_wdata, wb_data, wb_rd, branch_target=0.
REQ-029 rst during ACCESS abandons the access with no writeback; the first accept after deassertion behaves as from power-up.

Structure
REQ-030 State encoding and the control-bundle field layout belong in the shared pipeline package, alongside the other stage definitions.
REQ-031 Single module; the timeout counter is inline logic, not a sub-module.

Verification
REQ-032 ALU op ALUout=0x0000002A, r_d=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x2A, wb_rd=5, no dmem_req.
REQ-033 Load ALUout=0x100, ack after 3 ACCESS cycles with rdata=0xDEADBEEF -> dmem_req high exactly 3 cycles, ex_ready low exactly 3 cycles, then wb_data=0xDEADBEEF, wb_reg_write=1.
REQ-034 Store ALUout=0x104, regData2=0x55AA55AA, ack in the first ACCESS cycle -> dmem_we=1, dmem_wdata=0x55AA55AA, wb_valid with wb_reg_write=0.
REQ-035 Load ALUout=0x102 -> no dmem_req, err_align pulse, wb_reg_write=0; load with no ack for 16 cycles -> err_timeout=1 stays high, next op is accepted normally.
REQ-036 Branch with zero=1 and pc_n=0x40 -> pc_src pulse with branch_target=0x40; same with zero=0 -> pc_src stays 0; rst asserted mid-ACCESS -> dmem_req drops immediately and no wb_valid follows.
